// File: rtl/osd_pkg.sv
// Shared types and constants for the OSD line refresh scheduler.
// Holds the FSM state encoding and line address helper.
package osd_pkg;

    localparam int SIDX_W = 6;
    localparam logic [7:0] BLANK_CHAR = 8'h20;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        FINISH
    } osd_state_t;

    function automatic logic [10:0] line_base(
        input int         base,
        input int         stride,
        input logic [2:0] k
    );
        return 11'(base + int'(k) * stride);
    endfunction

endpackage

// File: rtl/osd_rr_picker.sv
// Circular first-set search over the dirty vector.
// Starts at start and wraps; idx is valid when found is high.
module osd_rr_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0] dirty,
    input  logic [2:0]   start,
    output logic         found,
    output logic [2:0]   idx
);

    logic [7:0] dirty_ext;
    logic [3:0] k;

    assign dirty_ext = 8'(dirty);

    always_comb begin
        found = 1'b0;
        idx   = 3'd0;
        k     = 4'd0;
        for (int i = 0; i < N; i++) begin
            k = 4'(start) + 4'(i);
            if (k >= 4'(N)) k = k - 4'(N);
            if (!found && dirty_ext[k[2:0]]) begin
                found = 1'b1;
                idx   = k[2:0];
            end
        end
    end

endmodule

// File: rtl/osd_line_refresh_scheduler.sv
// Keeps OSD text lines in step with their selection indices:
// blanks a changed line, restarts the string writer, owns the RAM port.
module osd_line_refresh_scheduler
    import osd_pkg::*;
#(
    parameter int NUM_LINES     = 4,
    parameter int LINE_COLS     = 32,
    parameter int ROW_STRIDE    = 32,
    parameter int BASE_ADDR     = 0,
    parameter int START_TIMEOUT = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [SIDX_W*NUM_LINES-1:0]   line_sel,
    input  logic                          force_refresh,
    output logic                          wr_start,
    output logic [SIDX_W-1:0]             wr_string_index,
    output logic [10:0]                   wr_base_addr,
    input  logic                          wr_busy,
    input  logic                          wr_en_in,
    input  logic [10:0]                   wr_addr_in,
    input  logic [7:0]                    wr_data_in,
    output logic                          ram_wr_en,
    output logic [10:0]                   ram_wr_addr,
    output logic [7:0]                    ram_wr_data,
    output logic                          busy,
    output logic                          line_done,
    output logic [2:0]                    line_done_idx
);

    localparam int SELW = 8 * SIDX_W;

    osd_state_t state, state_nxt;

    logic [7:0][SIDX_W-1:0] sel8;
    logic [NUM_LINES-1:0]   dirty;
    logic [NUM_LINES-1:0]   set_v;
    logic [NUM_LINES-1:0]   clr_v;
    logic                   pick_found;
    logic [2:0]             pick_idx;
    logic [2:0]             cur_line;
    logic [SIDX_W-1:0]      cur_sel;
    logic [10:0]            cur_base;
    logic [10:0]            col;
    logic [15:0]            tmo;
    logic [2:0]             rr_ptr;
    logic [10:0]            wr_off;
    logic                   in_line;

    assign sel8 = SELW'(line_sel);
    assign busy = (state != IDLE);

    osd_rr_picker #(
        .N(NUM_LINES)
    ) u_picker (
        .dirty(dirty),
        .start(rr_ptr),
        .found(pick_found),
        .idx  (pick_idx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        wr_start        = 1'b0;
        wr_string_index = '0;
        wr_base_addr    = '0;
        line_done       = 1'b0;
        line_done_idx   = 3'd0;
        unique case (state)
            IDLE: begin
                if (pick_found && !wr_busy) state_nxt = CLEAR;
            end
            CLEAR: begin
                if (col == 11'(LINE_COLS - 1)) state_nxt = START;
            end
            START: begin
                wr_start        = 1'b1;
                wr_string_index = cur_sel;
                wr_base_addr    = cur_base;
                state_nxt       = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (wr_busy)                              state_nxt = WAIT_DONE;
                else if (tmo == 16'(START_TIMEOUT - 1))   state_nxt = FINISH;
            end
            WAIT_DONE: begin
                if (!wr_busy) state_nxt = FINISH;
            end
            FINISH: begin
                line_done     = 1'b1;
                line_done_idx = cur_line;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_line <= 3'd0;
            cur_sel  <= '0;
            cur_base <= '0;
            col      <= '0;
            tmo      <= '0;
            rr_ptr   <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (state_nxt == CLEAR) begin
                        cur_line <= pick_idx;
                        cur_sel  <= sel8[pick_idx];
                        cur_base <= line_base(BASE_ADDR, ROW_STRIDE, pick_idx);
                        col      <= '0;
                    end
                end
                CLEAR:     col <= col + 11'd1;
                START:     tmo <= '0;
                WAIT_BUSY: tmo <= tmo + 16'd1;
                FINISH: begin
                    rr_ptr <= (cur_line == 3'(NUM_LINES - 1)) ? 3'd0
                                                              : cur_line + 3'd1;
                end
                default: ;
            endcase
        end
    end

    // served is compared post-update on the finishing line so a clean
    // finish does not immediately re-dirty it
    for (genvar k = 0; k < NUM_LINES; k++) begin : g_line
        logic [SIDX_W-1:0] served;
        logic              fin;

        assign fin = (state == FINISH) && (cur_line == 3'(k));

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)  served <= '0;
            else if (fin)  served <= cur_sel;
        end

        assign set_v[k] = force_refresh ||
                          (sel8[k] != (fin ? cur_sel : served));
        assign clr_v[k] = fin;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) dirty <= '1;
        else          dirty <= (dirty & ~clr_v) | set_v;
    end

    assign wr_off  = wr_addr_in - cur_base;
    assign in_line = (wr_off < 11'(LINE_COLS));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_wr_en   <= 1'b0;
            ram_wr_addr <= '0;
            ram_wr_data <= '0;
        end else if (state == CLEAR) begin
            ram_wr_en   <= 1'b1;
            ram_wr_addr <= cur_base + col;
            ram_wr_data <= BLANK_CHAR;
        end else if (state != IDLE && wr_en_in && in_line) begin
            ram_wr_en   <= 1'b1;
            ram_wr_addr <= wr_addr_in;
            ram_wr_data <= wr_data_in;
        end else begin
            ram_wr_en   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_osd_line_refresh_scheduler.sv
// Directed bench for osd_line_refresh_scheduler with a small
// string-writer model that paints "SNES" at the line base.
module tb_osd_line_refresh_scheduler;

    localparam int NL = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [6*NL-1:0] line_sel;
    logic          force_refresh;
    logic          wr_start;
    logic [5:0]    wr_string_index;
    logic [10:0]   wr_base_addr;
    logic          wr_busy;
    logic          wr_en_in;
    logic [10:0]   wr_addr_in;
    logic [7:0]    wr_data_in;
    logic          ram_wr_en;
    logic [10:0]   ram_wr_addr;
    logic [7:0]    ram_wr_data;
    logic          busy;
    logic          line_done;
    logic [2:0]    line_done_idx;

    logic          wb_model;
    logic          force_busy;
    logic [10:0]   wbase;
    int            wmode;
    int            oor_a_cyc;
    int            cycle = 0;
    int            compared = 0;
    int            mismatched = 0;

    logic [18:0]   ram_q[$];
    int            ram_cyc[$];
    logic [16:0]   start_q[$];
    int            start_cyc[$];
    logic [2:0]    done_q[$];
    int            done_cyc[$];

    assign wr_busy = wb_model | force_busy;

    osd_line_refresh_scheduler dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .line_sel       (line_sel),
        .force_refresh  (force_refresh),
        .wr_start       (wr_start),
        .wr_string_index(wr_string_index),
        .wr_base_addr   (wr_base_addr),
        .wr_busy        (wr_busy),
        .wr_en_in       (wr_en_in),
        .wr_addr_in     (wr_addr_in),
        .wr_data_in     (wr_data_in),
        .ram_wr_en      (ram_wr_en),
        .ram_wr_addr    (ram_wr_addr),
        .ram_wr_data    (ram_wr_data),
        .busy           (busy),
        .line_done      (line_done),
        .line_done_idx  (line_done_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (ram_wr_en) begin
            ram_q.push_back({ram_wr_addr, ram_wr_data});
            ram_cyc.push_back(cycle);
        end
        if (wr_start) begin
            start_q.push_back({wr_string_index, wr_base_addr});
            start_cyc.push_back(cycle);
        end
        if (line_done) begin
            done_q.push_back(line_done_idx);
            done_cyc.push_back(cycle);
        end
    end

    function automatic logic [7:0] snes(input int i);
        case (i)
            0, 3:    return 8'h53;
            1:       return 8'h4E;
            default: return 8'h45;
        endcase
    endfunction

    // Expected RAM write j of a normal refresh at base: 32 blanks then SNES
    function automatic logic [18:0] exp_norm(input int base, input int j);
        if (j < 32) return {11'(base + j), 8'h20};
        return {11'(base + j - 32), snes(j - 32)};
    endfunction

    function automatic int count_line_diffs(input int first, input int base,
                                            input int n);
        int bad = 0;
        for (int j = 0; j < n; j++) begin
            if (first + j >= ram_q.size()) bad++;
            else if (ram_q[first + j] !== exp_norm(base, j)) bad++;
        end
        return bad;
    endfunction

    // Writer model: mode 0 normal, 1 absent, 2 emits an out-of-line write
    initial begin
        wb_model   = 1'b0;
        wr_en_in   = 1'b0;
        wr_addr_in = '0;
        wr_data_in = '0;
        oor_a_cyc  = 0;
        forever begin
            @(negedge clk);
            if (wr_start && wmode != 1) begin
                wbase    = wr_base_addr;
                wb_model = 1'b1;
                for (int j = 0; j < ((wmode == 2) ? 3 : 4); j++) begin
                    @(negedge clk);
                    wr_en_in = 1'b1;
                    if (wmode == 2) begin
                        case (j)
                            0: begin
                                wr_addr_in = wbase;
                                wr_data_in = 8'h41;
                                oor_a_cyc  = cycle;
                            end
                            1: begin
                                wr_addr_in = wbase + 11'd40;
                                wr_data_in = 8'h58;
                            end
                            default: begin
                                wr_addr_in = wbase + 11'd1;
                                wr_data_in = 8'h42;
                            end
                        endcase
                    end else begin
                        wr_addr_in = wbase + 11'(j);
                        wr_data_in = snes(j);
                    end
                end
                @(negedge clk);
                wr_en_in = 1'b0;
                wb_model = 1'b0;
            end
        end
    end

    task automatic clear_logs();
        ram_q.delete();
        ram_cyc.delete();
        start_q.delete();
        start_cyc.delete();
        done_q.delete();
        done_cyc.delete();
    endtask

    task automatic wait_done(input int n, input int budget);
        for (int i = 0; i < budget && done_q.size() < n; i++) @(posedge clk);
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        force_refresh = 1'b0;
        force_busy    = 1'b0;
        wmode         = 0;
        line_sel      = {6'd10, 6'd17, 6'd16, 6'd0};
        repeat (3) @(negedge clk);
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        compared++;
        if (ram_wr_en !== 1'b0 || ram_wr_addr !== 11'd0) begin
            mismatched++;
            $display("FAIL reset_ram: got en=%b addr=%0d want 0/0",
                     ram_wr_en, ram_wr_addr);
        end
        compared++;
        if (wr_start !== 1'b0 || wr_base_addr !== 11'd0) begin
            mismatched++;
            $display("FAIL reset_start: got %b/%0d want 0/0",
                     wr_start, wr_base_addr);
        end
        compared++;
        if (line_done !== 1'b0 || line_done_idx !== 3'd0) begin
            mismatched++;
            $display("FAIL reset_done: got %b/%0d want 0/0",
                     line_done, line_done_idx);
        end
    endtask

    task automatic test_power_up();
        int e_idx[4];
        e_idx = '{0, 16, 17, 10};
        clear_logs();
        @(negedge clk);
        reset_n = 1'b1;
        wait_done(4, 2000);
        compared++;
        if (done_q.size() != 4 || ram_q.size() != 144) begin
            mismatched++;
            $display("FAIL pwr_counts: got done=%0d ram=%0d want 4/144",
                     done_q.size(), ram_q.size());
        end
        for (int r = 0; r < 4; r++) begin
            if (done_q.size() > r && start_q.size() > r) begin
                compared++;
                if (done_q[r] !== 3'(r) ||
                    start_q[r] !== {6'(e_idx[r]), 11'(32 * r)}) begin
                    mismatched++;
                    $display("FAIL pwr_line%0d: got done=%0d start=%h want %0d/%h",
                             r, done_q[r], start_q[r], r,
                             {6'(e_idx[r]), 11'(32 * r)});
                end
            end
            compared++;
            if (count_line_diffs(36 * r, 32 * r, 36) != 0) begin
                mismatched++;
                $display("FAIL pwr_ram%0d: got %0d bad writes want 0", r,
                         count_line_diffs(36 * r, 32 * r, 36));
            end
        end
    endtask

    task automatic test_single_change();
        clear_logs();
        @(negedge clk);
        line_sel[17:12] = 6'd19;
        wait_done(1, 500);
        repeat (40) @(posedge clk);
        @(negedge clk);
        compared++;
        if (done_q.size() != 1 || ram_q.size() != 36 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL single_counts: got done=%0d ram=%0d busy=%b want 1/36/0",
                     done_q.size(), ram_q.size(), busy);
        end
        if (done_q.size() > 0 && start_q.size() > 0) begin
            compared++;
            if (done_q[0] !== 3'd2 || start_q[0] !== {6'd19, 11'd64}) begin
                mismatched++;
                $display("FAIL single_line: got %0d/%h want 2/%h",
                         done_q[0], start_q[0], {6'd19, 11'd64});
            end
        end
        compared++;
        if (count_line_diffs(0, 64, 36) != 0) begin
            mismatched++;
            $display("FAIL single_ram: got %0d bad writes want 0",
                     count_line_diffs(0, 64, 36));
        end
    endtask

    task automatic test_force_mid_change();
        int  e_line[5];
        int  e_idx[5];
        bit  hit = 0;
        e_line = '{3, 0, 1, 2, 1};
        e_idx  = '{10, 0, 16, 19, 18};
        clear_logs();
        @(negedge clk);
        force_refresh = 1'b1;
        @(negedge clk);
        force_refresh = 1'b0;
        for (int i = 0; i < 1000 && !hit; i++) begin
            @(posedge clk);
            if (start_q.size() > 0 && start_q[$][16:11] == 6'd16) hit = 1;
        end
        if (hit) begin
            repeat (2) @(negedge clk);
            line_sel[11:6] = 6'd18;
        end
        compared++;
        if (!hit) begin
            mismatched++;
            $display("FAIL mid_seen: got no start of index 16 want one");
        end
        wait_done(5, 2000);
        repeat (40) @(posedge clk);
        compared++;
        if (done_q.size() != 5 || ram_q.size() != 180) begin
            mismatched++;
            $display("FAIL mid_counts: got done=%0d ram=%0d want 5/180",
                     done_q.size(), ram_q.size());
        end
        for (int r = 0; r < 5; r++) begin
            if (done_q.size() > r && start_q.size() > r) begin
                compared++;
                if (done_q[r] !== 3'(e_line[r]) ||
                    start_q[r] !== {6'(e_idx[r]), 11'(32 * e_line[r])}) begin
                    mismatched++;
                    $display("FAIL mid_ref%0d: got done=%0d start=%h want %0d/%h",
                             r, done_q[r], start_q[r], e_line[r],
                             {6'(e_idx[r]), 11'(32 * e_line[r])});
                end
            end
            compared++;
            if (count_line_diffs(36 * r, 32 * e_line[r], 36) != 0) begin
                mismatched++;
                $display("FAIL mid_ram%0d: got %0d bad writes want 0", r,
                         count_line_diffs(36 * r, 32 * e_line[r], 36));
            end
        end
    endtask

    task automatic test_timeout();
        clear_logs();
        wmode = 1;
        @(negedge clk);
        line_sel[23:18] = 6'd5;
        wait_done(1, 500);
        repeat (10) @(posedge clk);
        compared++;
        if (done_q.size() != 1 || ram_q.size() != 32) begin
            mismatched++;
            $display("FAIL tmo_counts: got done=%0d ram=%0d want 1/32",
                     done_q.size(), ram_q.size());
        end
        if (done_q.size() > 0 && start_q.size() > 0) begin
            compared++;
            if (done_q[0] !== 3'd3 || start_q[0] !== {6'd5, 11'd96} ||
                done_cyc[0] - start_cyc[0] != 5) begin
                mismatched++;
                $display("FAIL tmo_finish: got line=%0d start=%h gap=%0d want 3/%h/5",
                         done_q[0], start_q[0], done_cyc[0] - start_cyc[0],
                         {6'd5, 11'd96});
            end
        end
        compared++;
        if (count_line_diffs(0, 96, 32) != 0) begin
            mismatched++;
            $display("FAIL tmo_ram: got %0d bad blanks want 0",
                     count_line_diffs(0, 96, 32));
        end
        wmode = 0;
    endtask

    task automatic test_out_of_range();
        clear_logs();
        wmode = 2;
        @(negedge clk);
        line_sel[5:0] = 6'd7;
        wait_done(1, 500);
        repeat (10) @(posedge clk);
        compared++;
        if (ram_q.size() != 34) begin
            mismatched++;
            $display("FAIL oor_count: got %0d writes want 34", ram_q.size());
        end
        if (ram_q.size() >= 34) begin
            compared++;
            if (ram_q[32] !== {11'd0, 8'h41} || ram_q[33] !== {11'd1, 8'h42}) begin
                mismatched++;
                $display("FAIL oor_data: got %h %h want %h %h", ram_q[32],
                         ram_q[33], {11'd0, 8'h41}, {11'd1, 8'h42});
            end
            compared++;
            if (ram_cyc[32] - oor_a_cyc != 1) begin
                mismatched++;
                $display("FAIL oor_latency: got %0d want 1",
                         ram_cyc[32] - oor_a_cyc);
            end
        end
        compared++;
        if (count_line_diffs(0, 0, 32) != 0) begin
            mismatched++;
            $display("FAIL oor_blank: got %0d bad blanks want 0",
                     count_line_diffs(0, 0, 32));
        end
        wmode = 0;
    endtask

    task automatic test_reset_mid_clear();
        int e_idx[4];
        int bad = 0;
        e_idx = '{7, 18, 21, 5};
        clear_logs();
        @(negedge clk);
        line_sel[17:12] = 6'd21;
        for (int i = 0; i < 200 && ram_q.size() < 10; i++) @(posedge clk);
        @(negedge clk);
        reset_n    = 1'b0;
        force_busy = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        clear_logs();
        repeat (10) begin
            @(negedge clk);
            if (busy !== 1'b0 || ram_wr_en !== 1'b0 || wr_start !== 1'b0) bad++;
        end
        compared++;
        if (bad != 0) begin
            mismatched++;
            $display("FAIL rst_hold: got %0d active cycles want 0", bad);
        end
        force_busy = 1'b0;
        wait_done(4, 2000);
        compared++;
        if (done_q.size() != 4 || ram_q.size() != 144) begin
            mismatched++;
            $display("FAIL rst_counts: got done=%0d ram=%0d want 4/144",
                     done_q.size(), ram_q.size());
        end
        for (int r = 0; r < 4; r++) begin
            if (done_q.size() > r && start_q.size() > r) begin
                compared++;
                if (done_q[r] !== 3'(r) ||
                    start_q[r] !== {6'(e_idx[r]), 11'(32 * r)}) begin
                    mismatched++;
                    $display("FAIL rst_line%0d: got done=%0d start=%h want %0d/%h",
                             r, done_q[r], start_q[r], r,
                             {6'(e_idx[r]), 11'(32 * r)});
                end
            end
            compared++;
            if (count_line_diffs(36 * r, 32 * r, 36) != 0) begin
                mismatched++;
                $display("FAIL rst_ram%0d: got %0d bad writes want 0", r,
                         count_line_diffs(36 * r, 32 * r, 36));
            end
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_single_change();
        test_force_mid_change();
        test_timeout();
        test_out_of_range();
        test_reset_mid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
